game_sequencer: RTL and testbench
=================================

# game_sequencer

Drives one round of the reaction game: arms on a start press, runs a seconds countdown, opens the play window, and measures the player's reaction in ticks. It sits directly upstream of the game-mode selector. It produces the three level signals that the selector turns into `game_select`: `countdown_start`, `game_start` and `game_finish`. It also produces the countdown digit and the reaction result for the display path.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 1000, measurement tick rate; the default gives a 1 ms tick.
- `COUNTDOWN_S`, 3, countdown length in seconds; legal range 1–3.
- `TIMEOUT_TICKS`, 9999, maximum reaction count before timeout.
- `CNT_W`, 14, width of the reaction count; must hold `TIMEOUT_TICKS`.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start_btn` input 1: debounced, synchronised level; each rising edge is one start request.
- `player_btn` input 1: debounced, synchronised level; each rising edge is one reaction press.
- `countdown_start` output 1: high while in COUNTDOWN.
- `game_start` output 1: high while in PLAY.
- `game_finish` output 1: high while in DONE.
- `countdown_digit` output 2: seconds remaining; 0 outside COUNTDOWN.
- `reaction_ticks` output `CNT_W`: latched result, valid while in DONE.
- `timed_out` output 1: high in DONE when the round ended by timeout.
- `false_start` output 1: high in DONE when the round ended by an early press; only exists with `FALSE_START_DETECT_EN`.

## Operation
- Edge detection: one register per button; `rise = btn & ~btn_q`.
- Tick generator: counts `CLK_HZ/TICK_HZ` clocks, then emits a 1-cycle `tick`. It is cleared on every state entry, so every interval starts from zero.
- Second counter: counts `TICK_HZ` ticks, then emits a 1-cycle `sec`.
- States are IDLE, COUNTDOWN, PLAY and DONE. All outputs are registered.
- IDLE → COUNTDOWN on `start_btn` rise.
  - On entry: `countdown_digit = COUNTDOWN_S`; `reaction_ticks`, `timed_out` and `false_start` are cleared.
- COUNTDOWN: each `sec` decrements `countdown_digit`.
  - When a `sec` arrives with `countdown_digit == 1`: go to PLAY and set the digit to 0.
- PLAY: each `tick` increments the count.
  - `player_btn` rise → DONE; `reaction_ticks` latches the current count.
  - Count reaches `TIMEOUT_TICKS` → DONE with `timed_out = 1` and `reaction_ticks = TIMEOUT_TICKS`. The count saturates and never wraps.
- DONE → COUNTDOWN on `start_btn` rise. This is the same entry action as from IDLE. There is no return to IDLE except by reset.
- `start_btn` is ignored in COUNTDOWN and PLAY.
- Without the macro, `player_btn` is ignored outside PLAY.
- Simultaneous events:
  - Press rise and `tick` in the same cycle: the press wins and the count is latched without the increment.
  - Press rise on the cycle the count reaches `TIMEOUT_TICKS`: treated as a press; `timed_out = 0`.
- Exactly one of `countdown_start`, `game_start`, `game_finish` is high, or none is (IDLE).

## Timing
- Reset: state IDLE, all outputs 0, all counters 0. Reset takes effect asynchronously and releases on the next clock edge; reset during any state aborts the round.
- Button rise to state change: the new state is visible 1 cycle after the cycle in which `rise` is true, i.e. 2 clocks after the level changes.
- COUNTDOWN lasts exactly `COUNTDOWN_S*TICK_HZ*(CLK_HZ/TICK_HZ)` cycles.
- PLAY tick n occurs `n*(CLK_HZ/TICK_HZ)` cycles after PLAY entry.
- `reaction_ticks` and `timed_out` update on the same edge that sets `game_finish`.

## Configuration
- Macro: `FALSE_START_DETECT_EN`.
- Defined: a `player_btn` rise in COUNTDOWN goes to DONE with `false_start = 1`, `reaction_ticks = 0` and `timed_out = 0`.
- Undefined: the `false_start` port is absent and early presses are ignored.

## Structure
- Shared package holds:
  - the state enum with encodings IDLE = 2'd0, COUNTDOWN = 2'd1, PLAY = 2'd2, DONE = 2'd3;
  - the derived constant `TICK_DIV = CLK_HZ/TICK_HZ`.
- Sub-module: `tick_gen`, which takes a divide parameter and a synchronous `clear` input and produces the `tick` pulse.
- The state machine, second counter and reaction counter stay in `game_sequencer`.

## Test plan
All scenarios use `CLK_HZ=100`, `TICK_HZ=10`, `COUNTDOWN_S=3`, `TIMEOUT_TICKS=20`.
- Reset mid-PLAY: assert `rst_n = 0` → all outputs 0 immediately; after release, state is IDLE.
- Normal round: start rise at cycle 0 → `countdown_start` high at cycle 2 with digit 3. Digit steps 3→2→1 at 100-cycle spacing. `game_start` rises 300 cycles after countdown entry.
- Reaction: press so that its rise is sampled 7 ticks into PLAY → `game_finish = 1`, `reaction_ticks = 7`, `timed_out = 0`.
- Timeout: no press → DONE after 20 ticks (200 cycles) with `reaction_ticks = 20` and `timed_out = 1`. A later press has no effect.
- Boundaries:
  - Press rise coincident with tick 5 → `reaction_ticks = 5`.
  - Start pressed during PLAY → ignored.
  - Start pressed in DONE → COUNTDOWN with outputs cleared.
- `FALSE_START_DETECT_EN` defined: press during COUNTDOWN → DONE with `false_start = 1` and `reaction_ticks = 0`. Undefined: the same press is ignored and the round continues.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared types and constants for the reaction-game sequencer.
//   state_e  - round state, fixed encodings (IDLE=0, COUNTDOWN=1, PLAY=2, DONE=3)
//   TICK_DIV - clocks per measurement tick for the default clock/tick rates
//   calc_tick_div() - same derivation for arbitrary parameter values
package game_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StCountdown = 2'd1,
      StPlay      = 2'd2,
      StDone      = 2'd3
   } state_e;

   localparam int unsigned DEF_CLK_HZ  = 100_000_000;
   localparam int unsigned DEF_TICK_HZ = 1000;
   localparam int unsigned TICK_DIV    = DEF_CLK_HZ / DEF_TICK_HZ;

   function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                 input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/game_sequencer_tick.sv
// tick_gen: clock divider emitting a one-cycle tick every DIV clocks.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   clear_i - synchronous restart; the next interval starts from zero
//   tick_o  - high for one cycle at the end of each DIV-clock interval
module tick_gen
   import game_sequencer_pkg::*;
#(
   parameter int unsigned DIV = TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntMax);

   always_comb begin
      if (clear_i || (cnt_q == CntMax)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: one round of the reaction game (arm, countdown, play window, result).
//   clk, rst_n         - system clock, asynchronous active-low reset
//   start_btn          - start request level (rising edge = request)
//   player_btn         - reaction press level (rising edge = press)
//   countdown_start    - high in COUNTDOWN
//   game_start         - high in PLAY
//   game_finish        - high in DONE
//   countdown_digit    - seconds remaining, 0 outside COUNTDOWN
//   reaction_ticks     - latched reaction count, valid in DONE
//   timed_out          - round ended by timeout
//   false_start        - round ended by an early press (only with FALSE_START_DETECT_EN)
// Build option: define FALSE_START_DETECT_EN to end the round on a press during COUNTDOWN.
// All outputs are a registered image of the internal round state, so they trail it by one
// clock: a button level change shows on the outputs two clocks later.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned TICK_HZ       = 1000,
   parameter int unsigned COUNTDOWN_S   = 3,
   parameter int unsigned TIMEOUT_TICKS = 9999,
   parameter int unsigned CNT_W         = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_btn,
   input  logic             player_btn,
   output logic             countdown_start,
   output logic             game_start,
   output logic             game_finish,
   output logic [1:0]       countdown_digit,
   output logic [CNT_W-1:0] reaction_ticks,
`ifdef FALSE_START_DETECT_EN
   output logic             false_start,
`endif
   output logic             timed_out
);

   localparam int unsigned      TickDiv   = calc_tick_div(CLK_HZ, TICK_HZ);
   localparam int unsigned      SecW      = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
   localparam logic [SecW-1:0]  SecMax    = SecW'(TICK_HZ - 1);
   localparam logic [CNT_W-1:0] Timeout   = CNT_W'(TIMEOUT_TICKS);
   localparam logic [1:0]       DigitInit = 2'(COUNTDOWN_S);

   state_e           state_q, state_d;
   logic             start_q, player_q;
   logic             start_rise, player_rise;
   logic             tick, sec, enter;
   logic [SecW-1:0]  sec_cnt_q, sec_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       digit_q, digit_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             timeout_q, timeout_d;
`ifdef FALSE_START_DETECT_EN
   logic             false_q, false_d;
`endif

   assign start_rise  = start_btn & ~start_q;
   assign player_rise = player_btn & ~player_q;
   assign sec         = tick && (sec_cnt_q == SecMax);

   tick_gen #(
      .DIV (TickDiv)
   ) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (enter),
      .tick_o  (tick)
   );

   always_comb begin
      state_d   = state_q;
      sec_cnt_d = sec_cnt_q;
      count_d   = count_q;
      digit_d   = digit_q;
      result_d  = result_q;
      timeout_d = timeout_q;
`ifdef FALSE_START_DETECT_EN
      false_d   = false_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start_rise) begin
               state_d   = StCountdown;
               digit_d   = DigitInit;
               result_d  = '0;
               timeout_d = 1'b0;
`ifdef FALSE_START_DETECT_EN
               false_d   = 1'b0;
`endif
            end
         end
         StCountdown: begin
`ifdef FALSE_START_DETECT_EN
            if (player_rise) begin
               state_d   = StDone;
               digit_d   = '0;
               result_d  = '0;
               timeout_d = 1'b0;
               false_d   = 1'b1;
            end else
`endif
            if (sec) begin
               if (digit_q == 2'd1) begin
                  state_d = StPlay;
                  digit_d = '0;
               end else begin
                  digit_d = digit_q - 2'd1;
               end
            end
         end
         StPlay: begin
            // A press beats a same-cycle tick, so the pre-increment count is latched.
            if (player_rise) begin
               state_d  = StDone;
               result_d = count_q;
            end else if (tick) begin
               if (count_q >= Timeout - CNT_W'(1)) begin
                  state_d   = StDone;
                  count_d   = Timeout;
                  result_d  = Timeout;
                  timeout_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
      endcase

      // Every state entry restarts the tick and second timing from zero.
      enter = (state_d != state_q);
      if (enter) begin
         sec_cnt_d = '0;
         if (state_d == StPlay) begin
            count_d = '0;
         end
      end else if ((state_q == StCountdown) && tick) begin
         sec_cnt_d = sec ? '0 : sec_cnt_q + SecW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         start_q         <= 1'b0;
         player_q        <= 1'b0;
         sec_cnt_q       <= '0;
         count_q         <= '0;
         digit_q         <= '0;
         result_q        <= '0;
         timeout_q       <= 1'b0;
         countdown_start <= 1'b0;
         game_start      <= 1'b0;
         game_finish     <= 1'b0;
         countdown_digit <= '0;
         reaction_ticks  <= '0;
         timed_out       <= 1'b0;
`ifdef FALSE_START_DETECT_EN
         false_q         <= 1'b0;
         false_start     <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         start_q         <= start_btn;
         player_q        <= player_btn;
         sec_cnt_q       <= sec_cnt_d;
         count_q         <= count_d;
         digit_q         <= digit_d;
         result_q        <= result_d;
         timeout_q       <= timeout_d;
         countdown_start <= (state_q == StCountdown);
         game_start      <= (state_q == StPlay);
         game_finish     <= (state_q == StDone);
         countdown_digit <= digit_q;
         reaction_ticks  <= result_q;
         timed_out       <= timeout_q;
`ifdef FALSE_START_DETECT_EN
         false_q         <= false_d;
         false_start     <= false_q;
`endif
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a cycle-elapsed model of the round rules checked on every
// negative edge, plus literal expectations at hand-computed cycles.
module tb_game_sequencer;

   localparam int unsigned ClkHz   = 100;
   localparam int unsigned TickHz  = 10;
   localparam int unsigned CdS     = 3;
   localparam int unsigned ToTicks = 20;
   localparam int unsigned CntW    = 14;
   localparam int Div    = ClkHz / TickHz;   // clocks per tick
   localparam int SecCyc = TickHz * Div;     // clocks per second
   localparam int CdCyc  = CdS * SecCyc;     // countdown length in clocks
   localparam int ToCyc  = ToTicks * Div;    // play window length in clocks
`ifdef FALSE_START_DETECT_EN
   localparam bit FsEn = 1'b1;
`else
   localparam bit FsEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start_btn = 1'b0;
   logic            player_btn = 1'b0;
   logic            countdown_start, game_start, game_finish, timed_out;
   logic [1:0]      countdown_digit;
   logic [CntW-1:0] reaction_ticks;
   logic            act_fs;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   game_sequencer #(
      .CLK_HZ        (ClkHz),
      .TICK_HZ       (TickHz),
      .COUNTDOWN_S   (CdS),
      .TIMEOUT_TICKS (ToTicks),
      .CNT_W         (CntW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_btn       (start_btn),
      .player_btn      (player_btn),
      .countdown_start (countdown_start),
      .game_start      (game_start),
      .game_finish     (game_finish),
      .countdown_digit (countdown_digit),
      .reaction_ticks  (reaction_ticks),
`ifdef FALSE_START_DETECT_EN
      .false_start     (act_fs),
`endif
      .timed_out       (timed_out)
   );

`ifndef FALSE_START_DETECT_EN
   assign act_fs = 1'b0;
`endif

   // Model: phase 0 idle, 1 countdown, 2 play, 3 done; el = clocks since phase entry.
   // Outputs trail the round state by one clock, hence the snapshot before each update.
   int              ph = 0;
   int              el = 0;
   int              m_res = 0;
   bit              m_to = 1'b0, m_fs = 1'b0, ps = 1'b0, pp = 1'b0, rs, rp;
   logic [CntW+6:0] exp_v = '0;
   logic [CntW+6:0] act_v;

   always @(negedge clk) begin
      if (!rst_n) begin
         ph = 0; el = 0; m_res = 0; m_to = 1'b0; m_fs = 1'b0; ps = 1'b0; pp = 1'b0;
         exp_v = '0;
      end
      act_v = {countdown_start, game_start, game_finish, countdown_digit, reaction_ticks,
               timed_out, act_fs};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL per_cycle t=%0t: got cs/gs/gf=%b%b%b dig=%0d res=%0d to=%b fs=%b, want %b%b%b dig=%0d res=%0d to=%b fs=%b",
                  $time, act_v[CntW+6], act_v[CntW+5], act_v[CntW+4], act_v[CntW+3:CntW+2],
                  act_v[CntW+1:2], act_v[1], act_v[0], exp_v[CntW+6], exp_v[CntW+5],
                  exp_v[CntW+4], exp_v[CntW+3:CntW+2], exp_v[CntW+1:2], exp_v[1], exp_v[0]);
      end
      if (rst_n) begin
         exp_v = {ph == 1, ph == 2, ph == 3, 2'((ph == 1) ? (int'(CdS) - el / SecCyc) : 0),
                  CntW'(m_res), m_to, m_fs};
         rs = start_btn && !ps;
         rp = player_btn && !pp;
         ps = start_btn;
         pp = player_btn;
         case (ph)
            0, 3: if (rs) begin
               ph = 1; el = 0; m_res = 0; m_to = 1'b0; m_fs = 1'b0;
            end
            1: if (FsEn && rp) begin
               ph = 3; m_fs = 1'b1;
            end else if (el == CdCyc - 1) begin
               ph = 2; el = 0;
            end else begin
               el++;
            end
            2: if (rp) begin
               ph = 3; m_res = el / Div;     // whole ticks elapsed at the press
            end else if (el == ToCyc - 1) begin
               ph = 3; m_res = ToTicks; m_to = 1'b1;
            end else begin
               el++;
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Advance to just after rising edge k.
   task automatic goto_edge(input int k);
      while (cyc < k) begin
         @(posedge clk);
         cyc++;
      end
   endtask

   // Advance to the falling edge that follows rising edge k.
   task automatic sample_at(input int k);
      goto_edge(k);
      @(negedge clk);
   endtask

   task automatic drive_at(input int k, input bit s, input bit p);
      goto_edge(k);
      #1;
      start_btn  = s;
      player_btn = p;
   endtask

   initial begin
      // Power-on reset.
      sample_at(2);
      check("reset_cs", countdown_start, 0);
      check("reset_res", reaction_ticks, 0);
      goto_edge(3);
      #1 rst_n = 1'b1;

      // Round 1: start rise in cycle 10 -> countdown visible after edge 12.
      drive_at(10, 1'b1, 1'b0);
      sample_at(11);
      check("cs_not_yet", countdown_start, 0);
      sample_at(12);
      check("cs_entry", countdown_start, 1);
      check("digit_3", countdown_digit, 3);
      drive_at(15, 1'b0, 1'b0);
      sample_at(111);
      check("digit_still_3", countdown_digit, 3);
      sample_at(112);
      check("digit_2", countdown_digit, 2);
      sample_at(212);
      check("digit_1", countdown_digit, 1);
      sample_at(311);
      check("gs_not_yet", game_start, 0);
      sample_at(312);
      check("gs_after_300", game_start, 1);
      check("digit_0_play", countdown_digit, 0);
      // Round state enters PLAY at edge 311; rise in cycle 386 sees 75 clocks = 7 ticks.
      drive_at(386, 1'b0, 1'b1);
      sample_at(387);
      check("gf_not_yet", game_finish, 0);
      sample_at(388);
      check("gf_press", game_finish, 1);
      check("react_7", reaction_ticks, 7);
      check("react_7_to", timed_out, 0);
      drive_at(395, 1'b0, 1'b0);

      // Round 2: restart from DONE clears the result.
      drive_at(400, 1'b1, 1'b0);
      sample_at(402);
      check("restart_cs", countdown_start, 1);
      check("restart_gf", game_finish, 0);
      check("restart_res", reaction_ticks, 0);
      check("restart_digit", countdown_digit, 3);
      drive_at(405, 1'b0, 1'b0);
      drive_at(720, 1'b1, 1'b0);          // start press in PLAY
      drive_at(725, 1'b0, 1'b0);
      sample_at(730);
      check("start_in_play_ignored", game_start, 1);
      // PLAY entered at edge 701; cycle 760 carries the tick that would move 5 -> 6.
      drive_at(760, 1'b0, 1'b1);
      sample_at(762);
      check("tick_press_gf", game_finish, 1);
      check("tick_press_res", reaction_ticks, 5);
      drive_at(770, 1'b0, 1'b0);

      // Round 3: timeout 200 clocks into PLAY.
      drive_at(800, 1'b1, 1'b0);
      drive_at(805, 1'b0, 1'b0);
      sample_at(1301);
      check("to_gs_before", game_start, 1);
      sample_at(1302);
      check("to_gf", game_finish, 1);
      check("to_res", reaction_ticks, 20);
      check("to_flag", timed_out, 1);
      drive_at(1320, 1'b0, 1'b1);
      sample_at(1330);
      check("late_press_res", reaction_ticks, 20);
      check("late_press_to", timed_out, 1);
      drive_at(1335, 1'b0, 1'b0);

      // Round 4: press during COUNTDOWN.
      drive_at(1400, 1'b1, 1'b0);
      drive_at(1405, 1'b0, 1'b0);
      drive_at(1450, 1'b0, 1'b1);
      sample_at(1452);
`ifdef FALSE_START_DETECT_EN
      check("fs_gf", game_finish, 1);
      check("fs_flag", act_fs, 1);
      check("fs_res", reaction_ticks, 0);
      check("fs_to", timed_out, 0);
`else
      check("early_ignored_cs", countdown_start, 1);
      check("early_ignored_gf", game_finish, 0);
`endif
      drive_at(1460, 1'b0, 1'b0);
      sample_at(1702);
`ifdef FALSE_START_DETECT_EN
      check("fs_stays_done", game_finish, 1);
`else
      check("early_round_plays", game_start, 1);
`endif

      // Round 5: reset in the middle of PLAY.
      drive_at(2000, 1'b1, 1'b0);
      drive_at(2005, 1'b0, 1'b0);
      sample_at(2350);
      check("pre_reset_gs", game_start, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_gs", game_start, 0);
      check("async_reset_vec", int'({countdown_start, game_finish, countdown_digit,
                                      reaction_ticks, timed_out, act_fs}), 0);
      goto_edge(2353);
      #1 rst_n = 1'b1;
      sample_at(2360);
      check("idle_after_reset", int'({countdown_start, game_start, game_finish}), 0);
      drive_at(2361, 1'b1, 1'b0);
      sample_at(2363);
      check("restart_from_idle", countdown_start, 1);
      drive_at(2365, 1'b0, 1'b0);
      sample_at(2370);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
